fifo_unpacker: RTL

Read-side companion to the single-entry `fifo`. Drives its `POP`, samples its `EMPTY`/`DOUT`, and serialises each popped word of `BEAT_W*RATIO` bits into `RATIO` beats of `BEAT_W` bits. Beats go downstream on a valid/ready handshake, lowest beat first. Sits between a wide pipeline FIFO and a narrower consumer, and supports a synchronous pipeline flush.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_unpacker_if.sv | 29 ++
 rtl/fifo_unpacker.sv | 76 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo read-side blocks.
package fifo_pkg;

    typedef enum logic {
        UNPK_IDLE = 1'b0,
        UNPK_SEND = 1'b1
    } unpk_state_e;

    // Beat index width; never narrower than one bit so RATIO=1 still has a port.
    function automatic int idx_w(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_unpacker_if.sv
// Upstream FIFO read port plus downstream beat handshake for fifo_unpacker.
interface fifo_unpacker_if #(
    parameter int BEAT_W = 32,
    parameter int RATIO  = 2
);
    localparam int IDX_W  = fifo_pkg::idx_w(RATIO);
    localparam int WORD_W = BEAT_W * RATIO;

    logic              FLUSH;
    logic              EMPTY_I;
    logic [WORD_W-1:0] DOUT_I;
    logic              POP_O;
    logic              BEAT_VALID;
    logic [BEAT_W-1:0] BEAT_DATA;
    logic [IDX_W-1:0]  BEAT_IDX;
    logic              BEAT_LAST;
    logic              BEAT_READY;

    modport master (
        input  FLUSH, EMPTY_I, DOUT_I, BEAT_READY,
        output POP_O, BEAT_VALID, BEAT_DATA, BEAT_IDX, BEAT_LAST
    );

    modport slave (
        output FLUSH, EMPTY_I, DOUT_I, BEAT_READY,
        input  POP_O, BEAT_VALID, BEAT_DATA, BEAT_IDX, BEAT_LAST
    );

endinterface

// File: rtl/fifo_unpacker.sv
// Pops wide words from the upstream FIFO and serialises them into RATIO beats,
// lowest beat first, with a synchronous flush of the held word.
//
// state     | meaning
// UNPK_IDLE | no word held; pop whenever upstream is non-empty
// UNPK_SEND | word held; beat idx_q presented downstream
module fifo_unpacker
    import fifo_pkg::*;
#(
    parameter int BEAT_W = 32,
    parameter int RATIO  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    fifo_unpacker_if.master  bus
);

    localparam int IDX_W  = idx_w(RATIO);
    localparam int WORD_W = BEAT_W * RATIO;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    unpk_state_e       valid_q, valid_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [WORD_W-1:0] word_q,  word_d;

    logic beat_valid;
    logic beat_last;
    logic fire;
    logic free;
    logic pop;

    assign beat_valid = (valid_q == UNPK_SEND);
    assign beat_last  = beat_valid && (idx_q == LAST_IDX);
    assign fire       = beat_valid && bus.BEAT_READY;
    // A last-beat fire frees the slot in the same cycle so words stream without a bubble.
    assign free       = !beat_valid || (fire && beat_last);
    assign pop        = reset_n && !bus.FLUSH && !bus.EMPTY_I && free;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        word_d  = word_q;
        if (bus.FLUSH) begin
            valid_d = UNPK_IDLE;
            idx_d   = '0;
        end else if (pop) begin
            valid_d = UNPK_SEND;
            idx_d   = '0;
            word_d  = bus.DOUT_I;
        end else if (fire && beat_last) begin
            valid_d = UNPK_IDLE;
            idx_d   = '0;
        end else if (fire) begin
            idx_d   = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= UNPK_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    assign bus.POP_O      = pop;
    assign bus.BEAT_VALID = beat_valid;
    assign bus.BEAT_DATA  = word_q[idx_q * BEAT_W +: BEAT_W];
    assign bus.BEAT_IDX   = idx_q;
    assign bus.BEAT_LAST  = beat_last;

endmodule
